aer_event_arbiter: RTL and testbench

- Parametrised two-level row/column arbiter for the event-based-camera pixel array.
- Serves ROWS x COLS pixel event requests in row-burst mode: a round-robin row grant takes a snapshot of that row's requesting columns, then serves the snapshot in ascending column order.
- Each served event is emitted as an (x = row, y = column, polarity) word over a valid/ready stream, and a one-cycle acknowledge pulse goes back to the pixel.
- Sits between the pixel array and the event FIFO/packetiser. Adds burst capping and backpressure on top of the fixed 8x8 arbitration.

---
 rtl/aer_event_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_aer_event_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_event_arbiter.sv
// Two-level AER arbiter: round-robin row grant, then ascending-column burst out of a row snapshot.
// Optional AER_TIMESTAMP_EN adds a free-running counter and a per-event timestamp output ts_o.
//
// state | meaning
// IDLE  | no row granted; pick next requesting row at/after row_ptr
// COL   | row granted; serve snapshot columns lowest-first, one per free slot
module aer_event_arbiter #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int POLARITY  = 2,
  parameter int X_WIDTH   = $clog2(ROWS),
  parameter int Y_WIDTH   = $clog2(COLS),
  parameter int MAX_BURST = COLS,
  parameter int TS_WIDTH  = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [ROWS*COLS-1:0]          req_i,
  input  logic [ROWS*COLS*POLARITY-1:0] pol_i,
  output logic [ROWS*COLS-1:0]          ack_o,
  output logic                         evt_valid_o,
  input  logic                         evt_ready_i,
  output logic [X_WIDTH-1:0]           x_o,
  output logic [Y_WIDTH-1:0]           y_o,
  output logic [POLARITY-1:0]          pol_o,
`ifdef AER_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]          ts_o,
`endif
  output logic                         row_busy_o
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, COL} state_t;

  state_t                  state_q, state_d;
  logic [X_WIDTH-1:0]      row_ptr_q, row_ptr_d;
  logic [X_WIDTH-1:0]      gr_q, gr_d;
  logic [COLS-1:0]         snap_q, snap_d;
  logic [COLS-1:0]         served_q, served_d;
  logic [BW-1:0]           burst_q, burst_d;
  logic                    valid_q, valid_d;
  logic [X_WIDTH-1:0]      x_q, x_d;
  logic [Y_WIDTH-1:0]      y_q, y_d;
  logic [POLARITY-1:0]     pol_q, pol_d;
  logic [ROWS*COLS-1:0]    ack_q, ack_d;

  logic                    found;
  logic [X_WIDTH-1:0]      sel_row;
  logic                    pick_vld;
  logic [Y_WIDTH-1:0]      pick;
  logic [COLS-1:0]         pending;
  logic [COLS-1:0]         col_oh;
  logic                    slot_free;
  logic                    load;

  assign pending   = snap_q & ~served_q;
  assign slot_free = !valid_q || evt_ready_i;
  assign load      = (state_q == COL) && slot_free && pick_vld;
  assign col_oh    = COLS'(1) << pick;

  // Rotating row search starting at row_ptr, wrapping modulo ROWS.
  always_comb begin
    int idx;
    found   = 1'b0;
    sel_row = '0;
    idx     = 0;
    for (int i = 0; i < ROWS; i++) begin
      idx = int'(row_ptr_q) + i;
      if (idx >= ROWS) idx = idx - ROWS;
      if (!found && (req_i[idx*COLS +: COLS] != '0)) begin
        found   = 1'b1;
        sel_row = X_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (pending[c]) begin
        pick_vld = 1'b1;
        pick     = Y_WIDTH'(c);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    row_ptr_d = row_ptr_q;
    gr_d      = gr_q;
    snap_d    = snap_q;
    served_d  = served_q;
    burst_d   = burst_q;
    valid_d   = valid_q;
    x_d       = x_q;
    y_d       = y_q;
    pol_d     = pol_q;
    ack_d     = '0;

    if (valid_q && evt_ready_i) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          gr_d     = sel_row;
          snap_d   = req_i[int'(sel_row)*COLS +: COLS];
          served_d = '0;
          burst_d  = '0;
          state_d  = COL;
        end
      end
      COL: begin
        if (load) begin
          valid_d  = 1'b1;
          x_d      = gr_q;
          y_d      = pick;
          pol_d    = pol_i[(int'(gr_q)*COLS + int'(pick))*POLARITY +: POLARITY];
          ack_d[int'(gr_q)*COLS + int'(pick)] = 1'b1;
          served_d = served_q | col_oh;
          burst_d  = burst_q + 1'b1;
          // Leave on the last load edge so the next row can follow back-to-back.
          if (((pending & ~col_oh) == '0) || (burst_q + 1'b1 == BW'(MAX_BURST))) begin
            state_d   = IDLE;
            row_ptr_d = (gr_q == X_WIDTH'(ROWS - 1)) ? '0 : gr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      row_ptr_q <= '0;
      gr_q      <= '0;
      snap_q    <= '0;
      served_q  <= '0;
      burst_q   <= '0;
      valid_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      pol_q     <= '0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      row_ptr_q <= row_ptr_d;
      gr_q      <= gr_d;
      snap_q    <= snap_d;
      served_q  <= served_d;
      burst_q   <= burst_d;
      valid_q   <= valid_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pol_q     <= pol_d;
      ack_q     <= ack_d;
    end
  end

`ifdef AER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt_q;
  logic [TS_WIDTH-1:0] ts_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 1'b1;
      if (load) ts_q <= ts_cnt_q;
    end
  end

  assign ts_o = ts_q;
`endif

  assign ack_o       = ack_q;
  assign evt_valid_o = valid_q;
  assign x_o         = x_q;
  assign y_o         = y_q;
  assign pol_o       = pol_q;
  assign row_busy_o  = (state_q == COL);

endmodule

// File: tb/tb_aer_event_arbiter.sv
// Randomized/directed bench for aer_event_arbiter against an event-order reference model.
module tb_aer_event_arbiter;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int POL  = 2;
  localparam int NPIX = ROWS * COLS;
  localparam int MAXB = 3;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic [1:0] pol;
  } evt_t;

  logic                clk_i = 1'b0;
  logic                reset_n_i;
  logic [NPIX-1:0]     req;
  logic [NPIX*POL-1:0] pol_v;
  logic [NPIX-1:0]     ack_o;
  logic                evt_valid_o;
  logic                evt_ready;
  logic [2:0]          x_o;
  logic [2:0]          y_o;
  logic [1:0]          pol_o;
  logic                row_busy_o;
`ifdef AER_TIMESTAMP_EN
  logic [15:0]         ts;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  int   m_ptr = 0;
  int   ack_cnt = 0;
  bit   rand_ready = 0;
  evt_t exp_q[$];
  evt_t got_q[$];

  aer_event_arbiter #(.ROWS(ROWS), .COLS(COLS), .POLARITY(POL), .MAX_BURST(MAXB)) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .req_i(req),
    .pol_i(pol_v),
    .ack_o(ack_o),
    .evt_valid_o(evt_valid_o),
    .evt_ready_i(evt_ready),
    .x_o(x_o),
    .y_o(y_o),
    .pol_o(pol_o),
`ifdef AER_TIMESTAMP_EN
    .ts_o(ts),
`endif
    .row_busy_o(row_busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [1:0] pix_pol(input int r, input int c);
    return pol_v[(r*COLS + c)*POL +: POL];
  endfunction

  // Event-order model: rotating row pick, ascending columns, at most MAXB per grant.
  task automatic predict(input logic [NPIX-1:0] p_in);
    logic [NPIX-1:0] p;
    int r, n;
    evt_t e;
    p = p_in;
    while (p != '0) begin
      r = -1;
      for (int i = 0; i < ROWS; i++)
        if (r < 0 && p[((m_ptr + i) % ROWS)*COLS +: COLS] != '0) r = (m_ptr + i) % ROWS;
      n = 0;
      for (int c = 0; c < COLS; c++) begin
        if (p[r*COLS + c] && n < MAXB) begin
          e.x = 3'(r); e.y = 3'(c); e.pol = pix_pol(r, c);
          exp_q.push_back(e);
          p[r*COLS + c] = 1'b0;
          n++;
        end
      end
      m_ptr = (r + 1) % ROWS;
    end
  endtask

  // One clock; pixels drop their request as soon as they see the ack.
  task automatic step();
    logic acc;
    evt_t e;
    acc = evt_valid_o && evt_ready;
    e.x = x_o; e.y = y_o; e.pol = pol_o;
    @(posedge clk_i); #1;
    if (acc) got_q.push_back(e);
    if (ack_o != '0) begin
      ack_cnt++;
      req = req & ~ack_o;
    end
    if (rand_ready) evt_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain(input int n, input int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      step();
      k++;
    end
    repeat (4) step();
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; req = '0; evt_ready = 1'b0;
    for (int i = 0; i < NPIX; i++) pol_v[i*POL +: POL] = 2'($urandom_range(0, 3));
    #22;
    n_vec++;
    if ({ack_o, evt_valid_o, x_o, y_o, pol_o, row_busy_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outs: got ack=%h v=%b x=%0d y=%0d pol=%0d busy=%b, want all 0",
               ack_o, evt_valid_o, x_o, y_o, pol_o, row_busy_o);
    end
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    n_vec++;
    if ({ack_o, evt_valid_o, row_busy_o} !== '0) begin
      n_err++;
      $display("FAIL reset_idle: got ack=%h v=%b busy=%b, want 0", ack_o, evt_valid_o, row_busy_o);
    end
    m_ptr = 0;
  endtask

  task automatic test_single();
    logic [NPIX-1:0] exp_ack;
    exp_q.delete(); got_q.delete();
    evt_ready = 1'b1; rand_ready = 0;
    req = '0; req[2*COLS + 5] = 1'b1;
    predict(req);
    step();
    n_vec++;
    if (row_busy_o !== 1'b1 || evt_valid_o !== 1'b0 || ack_o !== '0) begin
      n_err++;
      $display("FAIL single_edge1: got busy=%b v=%b ack=%h, want busy=1 v=0 ack=0", row_busy_o, evt_valid_o, ack_o);
    end
    step();
    exp_ack = '0; exp_ack[21] = 1'b1;
    n_vec++;
    if (evt_valid_o !== 1'b1 || x_o !== 3'd2 || y_o !== 3'd5 || pol_o !== pix_pol(2, 5) || ack_o !== exp_ack) begin
      n_err++;
      $display("FAIL single_edge2: got v=%b x=%0d y=%0d pol=%0d ack=%h, want v=1 x=2 y=5 pol=%0d ack=%h",
               evt_valid_o, x_o, y_o, pol_o, ack_o, pix_pol(2, 5), exp_ack);
    end
    n_vec++;
    if (row_busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL single_exit: got busy=%b, want 0", row_busy_o);
    end
    step();
    n_vec++;
    if (evt_valid_o !== 1'b0 || ack_o !== '0) begin
      n_err++;
      $display("FAIL single_accept: got v=%b ack=%h, want v=0 ack=0", evt_valid_o, ack_o);
    end
    // Row pointer now past row 2: row 4 must win over row 0.
    req = '0; req[0*COLS + 1] = 1'b1; req[4*COLS + 6] = 1'b1;
    predict(req);
    drain(exp_q.size(), 40);
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL single_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL single_evt[%0d]: got x=%0d y=%0d pol=%0d, want x=%0d y=%0d pol=%0d",
                 i, got_q[i].x, got_q[i].y, got_q[i].pol, exp_q[i].x, exp_q[i].y, exp_q[i].pol);
      end
    end
  endtask

  task automatic test_row_burst();
    exp_q.delete(); got_q.delete();
    evt_ready = 1'b1; rand_ready = 0;
    req = '0; req[1*COLS + 0] = 1'b1; req[1*COLS + 3] = 1'b1; req[1*COLS + 7] = 1'b1;
    predict(req);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (evt_valid_o !== 1'b1 || x_o !== 3'd1 || y_o !== exp_q[i].y || ack_o !== (NPIX'(1) << (8 + exp_q[i].y))) begin
        n_err++;
        $display("FAIL burst_evt[%0d]: got v=%b x=%0d y=%0d ack=%h, want v=1 x=1 y=%0d",
                 i, evt_valid_o, x_o, y_o, ack_o, exp_q[i].y);
      end
    end
    step();
    n_vec++;
    if (evt_valid_o !== 1'b0 || got_q.size() != 3) begin
      n_err++;
      $display("FAIL burst_end: got v=%b n=%0d, want v=0 n=3", evt_valid_o, got_q.size());
    end
  endtask

  task automatic test_round_robin();
    int first, second, k, want;
    got_q.delete();
    evt_ready = 1'b1; rand_ready = 0;
    first  = (m_ptr >= 1 && m_ptr <= 6) ? 6 : 0;
    second = (first == 6) ? 0 : 6;
    req = '0; req[0*COLS + 4] = 1'b1; req[6*COLS + 4] = 1'b1;
    k = 0;
    while (got_q.size() < 8 && k < 80) begin
      step();
      req[0*COLS + 4] = 1'b1; req[6*COLS + 4] = 1'b1;
      k++;
    end
    k = 0;
    while ((req != '0 || evt_valid_o) && k < 40) begin
      step();
      k++;
    end
    n_vec++;
    if (got_q.size() < 8 || req != '0) begin
      n_err++;
      $display("FAIL rr_count: got %0d events req=%h, want >=8 events req=0", got_q.size(), req);
    end
    for (int i = 0; i < got_q.size(); i++) begin
      want = (i % 2 == 0) ? first : second;
      n_vec++;
      if (got_q[i].x !== 3'(want) || got_q[i].y !== 3'd4) begin
        n_err++;
        $display("FAIL rr_evt[%0d]: got x=%0d y=%0d, want x=%0d y=4", i, got_q[i].x, got_q[i].y, want);
      end
    end
    if (got_q.size() > 0) m_ptr = ((((got_q.size() - 1) % 2 == 0) ? first : second) + 1) % ROWS;
  endtask

  task automatic test_burst_cap();
    exp_q.delete(); got_q.delete();
    evt_ready = 1'b1; rand_ready = 0;
    req = '0;
    req[3*COLS + 1] = 1'b1; req[3*COLS + 2] = 1'b1; req[3*COLS + 5] = 1'b1; req[3*COLS + 6] = 1'b1;
    req[5*COLS + 0] = 1'b1; req[0*COLS + 7] = 1'b1;
    predict(req);
    drain(exp_q.size(), 60);
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL cap_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL cap_evt[%0d]: got x=%0d y=%0d pol=%0d, want x=%0d y=%0d pol=%0d",
                 i, got_q[i].x, got_q[i].y, got_q[i].pol, exp_q[i].x, exp_q[i].y, exp_q[i].pol);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_q.delete(); got_q.delete();
    evt_ready = 1'b0; rand_ready = 0;
    req = '0; req[7*COLS + 2] = 1'b1; req[7*COLS + 4] = 1'b1;
    predict(req);
    step();
    step();
    n_vec++;
    if (evt_valid_o !== 1'b1 || x_o !== 3'd7 || y_o !== 3'd2 || ack_o !== (NPIX'(1) << 58)) begin
      n_err++;
      $display("FAIL bp_first: got v=%b x=%0d y=%0d ack=%h, want v=1 x=7 y=2", evt_valid_o, x_o, y_o, ack_o);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (evt_valid_o !== 1'b1 || x_o !== 3'd7 || y_o !== 3'd2 || pol_o !== pix_pol(7, 2) || ack_o !== '0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v=%b x=%0d y=%0d pol=%0d ack=%h, want v=1 x=7 y=2 pol=%0d ack=0",
                 i, evt_valid_o, x_o, y_o, pol_o, ack_o, pix_pol(7, 2));
      end
    end
    evt_ready = 1'b1;
    step();
    n_vec++;
    if (evt_valid_o !== 1'b1 || y_o !== 3'd4 || pol_o !== pix_pol(7, 4) || ack_o !== (NPIX'(1) << 60)) begin
      n_err++;
      $display("FAIL bp_release: got v=%b y=%0d pol=%0d ack=%h, want v=1 y=4 pol=%0d", evt_valid_o, y_o, pol_o, ack_o, pix_pol(7, 4));
    end
    step();
    n_vec++;
    if (got_q.size() != 2 || evt_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL bp_count: got %0d events v=%b, want 2 events v=0", got_q.size(), evt_valid_o);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL bp_evt[%0d]: got x=%0d y=%0d, want x=%0d y=%0d", i, got_q[i].x, got_q[i].y, exp_q[i].x, exp_q[i].y);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    exp_q.delete(); got_q.delete();
    evt_ready = 1'b0; rand_ready = 0;
    req = '0; req[4*COLS +: COLS] = '1;
    step();
    step();
    #2 reset_n_i = 1'b0;
    #1;
    n_vec++;
    if ({ack_o, evt_valid_o, x_o, y_o, pol_o, row_busy_o} !== '0) begin
      n_err++;
      $display("FAIL midrst_outs: got ack=%h v=%b x=%0d y=%0d pol=%0d busy=%b, want all 0",
               ack_o, evt_valid_o, x_o, y_o, pol_o, row_busy_o);
    end
    @(posedge clk_i); #3 reset_n_i = 1'b1;
    m_ptr = 0;
    req[1*COLS + 0] = 1'b1;
    predict(req);
    rand_ready = 1; evt_ready = 1'b1;
    drain(exp_q.size(), 120);
    n_vec++;
    if (got_q.size() != exp_q.size() || req != '0) begin
      n_err++;
      $display("FAIL midrst_count: got %0d events req=%h, want %0d events req=0", got_q.size(), req, exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL midrst_evt[%0d]: got x=%0d y=%0d pol=%0d, want x=%0d y=%0d pol=%0d",
                 i, got_q[i].x, got_q[i].y, got_q[i].pol, exp_q[i].x, exp_q[i].y, exp_q[i].pol);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      exp_q.delete(); got_q.delete();
      ack_cnt = 0;
      rand_ready = 1;
      for (int i = 0; i < NPIX; i++) pol_v[i*POL +: POL] = 2'($urandom_range(0, 3));
      for (int i = 0; i < NPIX; i++) req[i] = ($urandom_range(0, 5) == 0);
      predict(req);
      drain(exp_q.size(), 400);
      n_vec++;
      if (got_q.size() != exp_q.size() || ack_cnt != exp_q.size() || req != '0) begin
        n_err++;
        $display("FAIL rand_count[%0d]: got %0d events %0d acks req=%h, want %0d each req=0",
                 it, got_q.size(), ack_cnt, req, exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL rand_evt[%0d.%0d]: got x=%0d y=%0d pol=%0d, want x=%0d y=%0d pol=%0d",
                   it, i, got_q[i].x, got_q[i].y, got_q[i].pol, exp_q[i].x, exp_q[i].y, exp_q[i].pol);
        end
      end
    end
    rand_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_row_burst();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
